// File: rtl/fetch_unit.sv
// Instruction fetch stage: PCF, single-outstanding IMem handshake, IF/ID register.
// Define FETCH_PERF_EN to add the FetchCount/BubbleCount performance counters.
module fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pcp4_q, buf_pcp4_d;

    logic        redirect;
    logic        accept;
    logic        deliver;
    logic        idle_bubble;
    logic [31:0] dlv_instr;
    logic [31:0] dlv_pcp4;
    logic [31:0] pc_plus4;

    assign redirect = PCSrcD && !StallD;
    assign pc_plus4 = pcf_q + 32'd4;
    assign IMemAddr = pcf_q;
    assign IMemReq  = (state_q == S_REQ) && !StallF && !reset;
    assign accept   = IMemReq && IMemReady;

    assign InstrD   = instr_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

    always_comb begin
        state_d     = state_q;
        pcf_d       = pcf_q;
        instr_d     = instr_q;
        pcp4_d      = pcp4_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pcp4_d  = buf_pcp4_q;
        deliver     = 1'b0;
        idle_bubble = 1'b0;
        dlv_instr   = 32'd0;
        dlv_pcp4    = 32'd0;

        unique case (state_q)
            S_REQ: begin
                if (accept) begin
                    state_d = redirect ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = IMemValid ? S_REQ : S_DROP;
                end else if (IMemValid) begin
                    if (!StallD) begin
                        deliver   = 1'b1;
                        dlv_instr = IMemRData;
                        dlv_pcp4  = pc_plus4;
                        state_d   = S_REQ;
                    end else begin
                        buf_instr_d = IMemRData;
                        buf_pcp4_d  = pc_plus4;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (!StallD) begin
                    deliver   = 1'b1;
                    dlv_instr = buf_instr_q;
                    dlv_pcp4  = buf_pcp4_q;
                    state_d   = S_REQ;
                end
            end
            S_DROP: begin
                if (IMemValid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over delivery; a stalled IF/ID holds its value.
        if (redirect) begin
            pcf_d   = PCBranchD;
            instr_d = 32'd0;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
        end else if (deliver) begin
            pcf_d   = pc_plus4;
            instr_d = dlv_instr;
            pcp4_d  = dlv_pcp4;
            valid_d = 1'b1;
        end else if (!StallD) begin
            idle_bubble = 1'b1;
            instr_d     = 32'd0;
            pcp4_d      = 32'd0;
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pcf_q       <= 32'd0;
            instr_q     <= 32'd0;
            pcp4_q      <= 32'd0;
            valid_q     <= 1'b0;
            buf_instr_q <= 32'd0;
            buf_pcp4_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            pcf_q       <= pcf_d;
            instr_q     <= instr_d;
            pcp4_q      <= pcp4_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pcp4_q  <= buf_pcp4_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            if (deliver) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (idle_bubble) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign FetchCount  = fetch_cnt_q;
    assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-vector bench for fetch_unit: delivery, stalls, redirects, reset.
// Define FETCH_PERF_EN to also check the performance counters.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemReady;
    logic        IMemValid;
    logic [31:0] IMemRData;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] BubbleCount;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .PCSrcD    (PCSrcD),
        .PCBranchD (PCBranchD),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemReady (IMemReady),
        .IMemValid (IMemValid),
        .IMemRData (IMemRData),
        .InstrD    (InstrD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount  (FetchCount),
        .BubbleCount (BubbleCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        sf;
        logic        sd;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        vld;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_vd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic sf, input logic sd,
                       input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic vld,
                       input logic [31:0] rdata,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic e_vd);
        vec_t v;
        v.rst = rst; v.sf = sf; v.sd = sd; v.br = br; v.tgt = tgt;
        v.rdy = rdy; v.vld = vld; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_instr = e_instr;
        v.e_pc4 = e_pc4; v.e_vd = e_vd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic sf, input logic sd,
                         input logic br, input logic [31:0] tgt,
                         input logic rdy, input logic vld,
                         input logic [31:0] rdata);
        reset = rst; StallF = sf; StallD = sd; PCSrcD = br;
        PCBranchD = tgt; IMemReady = rdy; IMemValid = vld;
        IMemRData = rdata;
    endtask

    task automatic check_outs(input string tag, input logic e_req,
                              input logic [31:0] e_addr,
                              input logic [31:0] e_instr,
                              input logic [31:0] e_pc4, input logic e_vd);
        check({tag, ".IMemReq"}, {31'd0, IMemReq}, {31'd0, e_req});
        check({tag, ".IMemAddr"}, IMemAddr, e_addr);
        check({tag, ".InstrD"}, InstrD, e_instr);
        check({tag, ".PCPlus4D"}, PCPlus4D, e_pc4);
        check({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, e_vd});
    endtask

    initial begin
        drive(1'b1, 0, 0, 0, 32'd0, 0, 0, 32'd0);
        repeat (2) @(posedge clk);

        //   rst sf sd br tgt           rdy vld rdata         req addr          instr         pc4           vd
        add(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h4,        32'h0,        32'h4,        1);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h4,         0, 32'h4,        32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h8,        32'h4,        32'h8,        1);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h8,         0, 32'h8,        32'h0,        32'h0,        0);
        // StallD for 3 cycles across the data return
        add(0, 0, 1, 0, 32'h0,        1, 0, 32'h0,         1, 32'hC,        32'h8,        32'hC,        1);
        add(0, 0, 1, 0, 32'h0,        0, 1, 32'hC,         0, 32'hC,        32'h8,        32'hC,        1);
        add(0, 0, 1, 1, 32'h200,      0, 0, 32'h0,         0, 32'hC,        32'h8,        32'hC,        1);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'hC,        32'h8,        32'hC,        1);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h10,       32'hC,        32'h10,       1);
        add(0, 1, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h10,       32'h0,        32'h0,        0);
        // redirect in WAIT, late data dropped
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h10,       32'h0,        32'h0,        0);
        add(0, 0, 0, 1, 32'h100,      0, 0, 32'h0,         0, 32'h10,       32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h100,      32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF,  0, 32'h100,      32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h100,      32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h100,       0, 32'h100,      32'h0,        32'h0,        0);
        // redirect in REQ with acceptance -> DROP
        add(0, 0, 0, 1, 32'h40,       1, 0, 32'h0,         1, 32'h104,      32'h100,      32'h104,      1);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h55,        0, 32'h40,       32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h40,       32'h0,        32'h0,        0);
        // redirect beats same-cycle delivery
        add(0, 0, 0, 1, 32'hFFFFFFFC, 0, 1, 32'h77,        0, 32'h40,       32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h99,        1, 32'hFFFFFFFC, 32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'hFFFFFFFC, 32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'h1234,      0, 32'hFFFFFFFC, 32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,        32'h1234,     32'h0,        1);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'hABC,       0, 32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h4,        32'hABC,      32'h4,        1);
        // reset in WAIT, late data ignored
        add(1, 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h4,        32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 1, 32'hBAD,       1, 32'h0,        32'h0,        32'h0,        0);
        add(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        32'h0,        32'h0,        0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].br,
                  vecs[i].tgt, vecs[i].rdy, vecs[i].vld, vecs[i].rdata);
            @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_req,
                       vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc4,
                       vecs[i].e_vd);
        end

        // redirect while holding a buffered word discards the buffer
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        check_outs("hold.req", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 32'h0, 0, 1, 32'h5A);
        @(posedge clk); #1;
        drive(0, 0, 0, 1, 32'h300, 0, 0, 32'h0);
        @(negedge clk);
        check_outs("hold.redir", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        check_outs("hold.after", 1'b1, 32'h300, 32'h0, 32'h0, 1'b0);

`ifdef FETCH_PERF_EN
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            drive(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
            @(posedge clk); #1;
            drive(0, 0, 0, 0, 32'h0, 0, 1, 32'(k * 4));
        end
        @(posedge clk); #1;
        drive(0, 0, 1, 0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        check("perf.FetchCount", FetchCount, 32'd4);
        check("perf.BubbleCount", BubbleCount, 32'd4);
        check("perf.InstrD", InstrD, 32'hC);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 StallF  in  1  hazard stall for fetch; blocks new request issue.
REQ-005 StallD  in  1  hazard stall for decode; freezes IF/ID.
REQ-006 PCSrcD  in  1  taken-branch redirect from decode, qualified by !StallD.
REQ-007 PCBranchD  in  32  redirect target.
REQ-008 IMemReq  out  1  fetch request valid.
REQ-009 IMemAddr  out  32  fetch address, equal to PCF.
REQ-010 IMemReady  in  1  memory accepts the request when IMemReq&&IMemReady.
REQ-011 IMemValid  in  1  read data valid; at the earliest, one cycle after acceptance.
REQ-012 IMemRData  in  32  instruction word.
REQ-013 InstrD  out  32  IF/ID instruction; 0 (nop) when it holds a bubble.
REQ-014 PCPlus4D  out  32  IF/ID PC+4 of InstrD.
REQ-015 ValidD  out  1  IF/ID holds a real instruction.

Function
REQ-016 The block SHALL hold PCF (32 b), the address of the instruction in flight; PC arithmetic SHALL be modulo 2^32 (0xFFFFFFFC+4 = 0).
REQ-017 The FSM states SHALL be REQ, WAIT, HOLD and DROP, with at most one outstanding request.
REQ-018 REQ: IMemReq = !StallF. Accept -> WAIT. Otherwise stay in REQ.
REQ-019 WAIT, IMemValid, no redirect, !StallD: load IF/ID with {IMemRData, PCF+4, ValidD=1}; PCF <= PCF+4; go to REQ.
REQ-020 WAIT, IMemValid, no redirect, StallD: capture the word and PCF+4 in the hold buffer; go to HOLD.
REQ-021 HOLD, !StallD, no redirect: load IF/ID from the buffer; PCF <= PCF+4; go to REQ.
REQ-022 Redirect (PCSrcD && !StallD) SHALL set PCF <= PCBranchD and load a bubble into IF/ID. It SHALL take priority over any delivery in the same cycle.
REQ-023 Redirect next state SHALL be:
- REQ with no acceptance that cycle: REQ.
- REQ with acceptance that cycle: DROP.
- WAIT without IMemValid: DROP.
- WAIT with IMemValid: REQ, data discarded.
- HOLD: REQ, buffer discarded.
REQ-024 DROP: IMemReq=0. IMemValid discards the data and goes to REQ. A redirect while in DROP updates PCF only.
REQ-025 When !StallD and nothing is delivered and there is no redirect, IF/ID SHALL load a bubble (InstrD=0, PCPlus4D=0, ValidD=0).
REQ-026 When StallD is high, IF/ID SHALL hold its value, and PCSrcD SHALL be ignored.
REQ-027 IMemValid outside WAIT and DROP SHALL be ignored.
REQ-028 Throughput SHALL be at most one instruction every 2 cycles (REQ, then WAIT); delivery latency SHALL be one edge after IMemValid.

Reset
REQ-029 While reset is high, the block SHALL force:
- PCF = 0x00000000 and state = REQ.
- InstrD = 0, PCPlus4D = 0, ValidD = 0, and the hold buffer cleared.
- IMemReq = 0 while reset is asserted.
REQ-030 Reset mid-request SHALL abandon the outstanding access; a late IMemValid arriving in REQ SHALL be ignored.

Configuration
REQ-031 When macro FETCH_PERF_EN is defined, the block SHALL add outputs FetchCount (32) and BubbleCount (32).
- FetchCount increments on each IF/ID load with ValidD=1.
- BubbleCount increments on each bubble load per REQ-025.
- Both counters exclude redirect bubbles, reset to 0 and wrap at 2^32.
REQ-032 Without FETCH_PERF_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-033 Memory with 1-cycle latency and data = address, no stalls -> ValidD every 2nd cycle; InstrD sequence 0x0, 0x4, 0x8; PCPlus4D = InstrD+4.
REQ-034 StallD held 3 cycles while IMemValid arrives in WAIT -> IF/ID frozen for 3 cycles, then InstrD = held word; PCF advances once.
REQ-035 PCSrcD=1, PCBranchD=0x100 in WAIT, IMemValid 2 cycles later -> state DROP, that data discarded, next IMemAddr = 0x100, IF/ID bubble.
REQ-036 PCSrcD=1 together with StallD=1 -> no redirect; PCF unchanged.
REQ-037 Reset asserted in WAIT, then IMemValid -> data ignored, IMemAddr = 0 after reset, ValidD = 0.
REQ-038 With FETCH_PERF_EN: 4 delivered instructions and 4 idle cycles -> FetchCount = 4, BubbleCount = 4.
